// File: rtl/wb_select_if.sv
// Bundle of signals between the memory stage, the write-back select stage
// and the register file. The stage itself connects through the slave modport.
interface wb_select_if #(
    parameter int DATA_W = 32,
    parameter int NSRC   = 3,
    parameter int SEL_W  = 2,
    parameter int REG_AW = 5
);
    // Retiring instruction from the memory stage
    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_W-1:0]         sel;
    logic [NSRC*DATA_W-1:0]   src_data;
    logic [REG_AW-1:0]        rd_addr;
    logic                     reg_write;
    logic                     flush;

    // Load response
    logic                     mem_rsp_valid;
    logic [DATA_W-1:0]        mem_rsp_data;

    // Toward the register file
    logic                     wb_valid;
    logic                     wb_we;
    logic [REG_AW-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     wb_err;

    modport master (
        output in_valid, sel, src_data, rd_addr, reg_write, flush,
               mem_rsp_valid, mem_rsp_data,
        input  in_ready, wb_valid, wb_we, wb_addr, wb_data, wb_err
    );

    modport slave (
        input  in_valid, sel, src_data, rd_addr, reg_write, flush,
               mem_rsp_valid, mem_rsp_data,
        output in_ready, wb_valid, wb_we, wb_addr, wb_data, wb_err
    );
endinterface

// File: rtl/wb_select_stage.sv
// Registered write-back select stage. Picks one of NSRC result sources for
// the retiring instruction and registers data/address/write-enable toward
// the register file. When the load source is selected for a register write,
// the stage holds the instruction until the memory response arrives, or
// forces an error retire after TIMEOUT cycles of waiting.
module wb_select_stage #(
    parameter int DATA_W  = 32,
    parameter int NSRC    = 3,
    parameter int SEL_W   = 2,
    parameter int REG_AW  = 5,
    parameter int MEM_IDX = 1,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_select_if.slave bus
);

    // Counter must be able to hold TIMEOUT-1, the last waiting cycle index.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [REG_AW-1:0]   pend_addr_q, pend_addr_d;

    logic                wb_valid_q,  wb_valid_d;
    logic                wb_we_q,     wb_we_d;
    logic [REG_AW-1:0]   wb_addr_q,   wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q,   wb_data_d;
    logic                wb_err_q,    wb_err_d;

    logic                in_ready;
    logic                accept;
    logic                is_load;
    logic                last_wait;

    // Source mux; a select beyond the populated sources yields zero.
    function automatic logic [DATA_W-1:0] pick_source(
        input logic [SEL_W-1:0]       s,
        input logic [NSRC*DATA_W-1:0] flat
    );
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (s == SEL_W'(i)) begin
                r = flat[i*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    // Ready only looks at state and flush, so the upstream stage never sees
    // a path from its own valid/data back into ready.
    assign in_ready  = (state_q == IDLE) && !bus.flush;
    assign accept    = bus.in_valid && in_ready;
    assign is_load   = (bus.sel == SEL_W'(MEM_IDX)) && bus.reg_write;
    assign last_wait = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and next-output logic for the accept/wait controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_addr_d = pend_addr_q;
        wb_valid_d  = 1'b0;
        wb_err_d    = 1'b0;
        wb_we_d     = wb_we_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_load) begin
                        state_d     = WAIT_MEM;
                        cnt_d       = '0;
                        pend_addr_d = bus.rd_addr;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = bus.reg_write;
                        wb_addr_d  = bus.rd_addr;
                        wb_data_d  = pick_source(bus.sel, bus.src_data);
                    end
                end
            end

            WAIT_MEM: begin
                if (bus.flush) begin
                    // Killed load: drop it without any retire pulse.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.mem_rsp_valid) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    wb_valid_d = 1'b1;
                    wb_we_d    = 1'b1;
                    wb_addr_d  = pend_addr_q;
                    wb_data_d  = bus.mem_rsp_data;
                end else if (last_wait) begin
                    // Retire without writing so the pipeline keeps moving;
                    // the address still names the instruction that failed.
                    state_d    = IDLE;
                    cnt_d      = '0;
                    wb_valid_d = 1'b1;
                    wb_we_d    = 1'b0;
                    wb_addr_d  = pend_addr_q;
                    wb_data_d  = '0;
                    wb_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Controller state, wait counter and latched load destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Registered write-back outputs; data fields hold between retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_we    = wb_we_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_err   = wb_err_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_wb_select_stage;

    localparam int DATA_W  = 32;
    localparam int NSRC    = 3;
    localparam int SEL_W   = 2;
    localparam int REG_AW  = 5;
    localparam int MEM_IDX = 1;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    wb_select_if #(.DATA_W(DATA_W), .NSRC(NSRC), .SEL_W(SEL_W), .REG_AW(REG_AW)) bus ();

    wb_select_stage #(
        .DATA_W(DATA_W), .NSRC(NSRC), .SEL_W(SEL_W), .REG_AW(REG_AW),
        .MEM_IDX(MEM_IDX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int asserts = 0;
    int fails   = 0;

    // Reference model: a pending load is remembered with its accept cycle;
    // its outcome is decided from the cycle distance and the response.
    bit                 m_busy;
    int                 m_acc;
    int                 cyc;
    logic [REG_AW-1:0]  m_pend;
    logic               e_valid, e_we, e_err;
    logic [REG_AW-1:0]  e_addr;
    logic [DATA_W-1:0]  e_data;
    bit                 addr_known;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy     = 1'b0;
        m_acc      = 0;
        m_pend     = '0;
        e_valid    = 1'b0;
        e_we       = 1'b0;
        e_err      = 1'b0;
        e_addr     = '0;
        e_data     = '0;
        addr_known = 1'b1;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".wb_valid"}, bus.wb_valid, e_valid);
        chk({where, ".wb_err"},   bus.wb_err,   e_err);
        chk({where, ".wb_we"},    bus.wb_we,    e_we);
        chk({where, ".wb_data"},  bus.wb_data,  e_data);
        if (addr_known) chk({where, ".wb_addr"}, bus.wb_addr, e_addr);
    endtask

    // One clock cycle: drive inputs, check ready, advance model, check outputs.
    task automatic step(input logic v, input logic [SEL_W-1:0] s, input logic [REG_AW-1:0] rd,
                        input logic rw, input logic fl, input logic rv, input logic [DATA_W-1:0] rdat);
        bit ready;
        int si;
        bus.in_valid      = v;
        bus.sel           = s;
        bus.rd_addr       = rd;
        bus.reg_write     = rw;
        bus.flush         = fl;
        bus.mem_rsp_valid = rv;
        bus.mem_rsp_data  = rdat;
        #1;
        ready = !m_busy && !fl;
        chk("in_ready", bus.in_ready, ready);

        si      = int'(s);
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (m_busy) begin
            if (fl) begin
                m_busy = 1'b0;
            end else if (rv) begin
                e_valid = 1'b1; e_we = 1'b1; e_addr = m_pend; e_data = rdat;
                addr_known = 1'b1; m_busy = 1'b0;
            end else if (cyc - m_acc == TIMEOUT) begin
                e_valid = 1'b1; e_we = 1'b0; e_data = '0; e_err = 1'b1;
                addr_known = 1'b0; m_busy = 1'b0;
            end
        end else if (v && ready) begin
            if (si == MEM_IDX && rw) begin
                m_busy = 1'b1; m_pend = rd; m_acc = cyc;
            end else begin
                e_valid = 1'b1; e_we = rw; e_addr = rd; addr_known = 1'b1;
                e_data  = (si < NSRC) ? bus.src_data[si*DATA_W +: DATA_W] : '0;
            end
        end

        @(posedge clk);
        cyc++;
        #1;
        check_outputs("cyc");
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.sel           = '0;
        bus.src_data      = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
        bus.rd_addr       = '0;
        bus.reg_write     = 1'b0;
        bus.flush         = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        model_reset();
        cyc = 0;

        // Reset state
        #12;
        check_outputs("reset");
        chk("reset.in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back non-load accepts, sel 0, 2, 0
        step(1'b1, 2'd0, 5'd1, 1'b1, 1'b0, 1'b0, '0);
        chk("b2b0.data", bus.wb_data, 32'h11);
        step(1'b1, 2'd2, 5'd2, 1'b1, 1'b0, 1'b0, '0);
        chk("b2b1.data", bus.wb_data, 32'h33);
        step(1'b1, 2'd0, 5'd3, 1'b1, 1'b0, 1'b0, '0);
        chk("b2b2.data", bus.wb_data, 32'h11);

        // Select beyond the populated sources
        step(1'b1, 2'd3, 5'd7, 1'b1, 1'b0, 1'b0, '0);
        chk("sel3.data", bus.wb_data, 32'h0);
        chk("sel3.addr", bus.wb_addr, 5'd7);
        chk("sel3.we",   bus.wb_we,   1'b1);

        // Memory source without a register write retires immediately
        step(1'b1, 2'd1, 5'd8, 1'b0, 1'b0, 1'b0, '0);
        chk("memnw.data", bus.wb_data, 32'h22);

        // Load answered 3 cycles after accept
        step(1'b1, 2'd1, 5'd9, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("load.valid", bus.wb_valid, 1'b1);
        chk("load.data",  bus.wb_data,  32'hDEAD_BEEF);
        chk("load.addr",  bus.wb_addr,  5'd9);

        // Load with no response: timeout, then accept in the retire cycle
        step(1'b1, 2'd1, 5'd4, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < TIMEOUT; i++) step(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
        chk("tmo.err", bus.wb_err, 1'b1);
        chk("tmo.we",  bus.wb_we,  1'b0);
        step(1'b1, 2'd2, 5'd5, 1'b1, 1'b0, 1'b0, '0);

        // Response on the last waiting cycle still wins over timeout
        step(1'b1, 2'd1, 5'd6, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);

        // Flush together with the response kills the load
        step(1'b1, 2'd1, 5'd10, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D);
        step(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0);

        // Flush in IDLE blocks acceptance
        step(1'b1, 2'd0, 5'd11, 1'b1, 1'b1, 1'b0, '0);

        // Reset in the middle of a wait, then a stray response
        step(1'b1, 2'd1, 5'd12, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst");
        chk("midrst.in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'hBAD0_BAD0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bus.src_data = {$urandom, $urandom, $urandom};
            step(1'($urandom_range(0, 3) != 0),
                 SEL_W'($urandom_range(0, 3)),
                 REG_AW'($urandom),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 3) == 0),
                 DATA_W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    // Global time bound so a wedged simulation still terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
